// File: rtl/red_pitaya_sys_pkg.sv
// Shared types for the sys_* bus initiator: FSM states and the queued command word.
package red_pitaya_sys_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RSP   = 2'd3
  } sys_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [SEL_W-1:0]  sel;
  } sys_cmd_t;

  localparam int unsigned CMD_W = $bits(sys_cmd_t);

endpackage

// File: rtl/red_pitaya_sync_fifo.sv
// Synchronous FIFO with registered storage and registered full/empty flags.
// Pointers carry one extra MSB so full and empty are distinguishable.
module red_pitaya_sync_fifo #(
  parameter int unsigned WIDTH = 69,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    wr_ptr_nxt;
  logic [PW-1:0]    rd_ptr_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;
  assign wr_ptr_nxt = wr_ptr_q + PW'(do_push);
  assign rd_ptr_nxt = rd_ptr_q + PW'(do_pop);
  assign dout_o     = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer and flag update; flags are derived from next-state pointers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      empty_o  <= 1'b1;
      full_o   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_nxt;
      rd_ptr_q <= rd_ptr_nxt;
      empty_o  <= (wr_ptr_nxt == rd_ptr_nxt);
      full_o   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                  (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/red_pitaya_sys_initiator.sv
// sys_* bus initiator: pops queued commands, issues one strobe per command and
// returns exactly one response (ack, err or timeout) per command, in order.
module red_pitaya_sys_initiator
  import red_pitaya_sys_pkg::*;
#(
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned TMO_CYC   = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  input  logic [SEL_W-1:0]  cmd_sel_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_tmo_o,
  output logic [ADDR_W-1:0] sys_addr_o,
  output logic [DATA_W-1:0] sys_wdata_o,
  output logic [SEL_W-1:0]  sys_sel_o,
  output logic              sys_wen_o,
  output logic              sys_ren_o,
  input  logic [DATA_W-1:0] sys_rdata_i,
  input  logic              sys_err_i,
  input  logic              sys_ack_i,
  output logic              busy_o
);

  localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);

  sys_cmd_t          cmd_in;
  sys_cmd_t          cmd_head;
  logic [CMD_W-1:0]  fifo_dout;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;

  sys_state_t        state_q,   state_nxt;
  logic              we_q,      we_nxt;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic [SEL_W-1:0]  sel_nxt;
  logic              wen_nxt;
  logic              ren_nxt;
  logic              rsp_valid_nxt;
  logic [DATA_W-1:0] rsp_rdata_nxt;
  logic              rsp_err_nxt;
  logic              rsp_tmo_nxt;

  assign cmd_in = '{we: cmd_we_i, addr: cmd_addr_i, wdata: cmd_wdata_i, sel: cmd_sel_i};

  red_pitaya_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (cmd_valid_i),
    .din_i   (cmd_in),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign cmd_head    = sys_cmd_t'(fifo_dout);
  assign cmd_ready_o = ~fifo_full;
  assign busy_o      = (state_q != IDLE) | ~fifo_empty;

  // Next-state and output decode; everything holds unless a state acts on it
  always_comb begin
    state_nxt     = state_q;
    we_nxt        = we_q;
    tmo_cnt_nxt   = tmo_cnt_q;
    addr_nxt      = sys_addr_o;
    wdata_nxt     = sys_wdata_o;
    sel_nxt       = sys_sel_o;
    wen_nxt       = 1'b0;
    ren_nxt       = 1'b0;
    rsp_valid_nxt = rsp_valid_o;
    rsp_rdata_nxt = rsp_rdata_o;
    rsp_err_nxt   = rsp_err_o;
    rsp_tmo_nxt   = rsp_tmo_o;
    fifo_pop      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          addr_nxt  = cmd_head.addr;
          wdata_nxt = cmd_head.wdata;
          sel_nxt   = cmd_head.sel;
          we_nxt    = cmd_head.we;
          wen_nxt   = cmd_head.we;
          ren_nxt   = ~cmd_head.we;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        tmo_cnt_nxt = '0;
        state_nxt   = WAIT;
      end
      WAIT: begin
        // err wins over a coincident ack
        if (sys_err_i) begin
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = '0;
          rsp_err_nxt   = 1'b1;
          rsp_tmo_nxt   = 1'b0;
          state_nxt     = RSP;
        end else if (sys_ack_i) begin
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = we_q ? '0 : sys_rdata_i;
          rsp_err_nxt   = 1'b0;
          rsp_tmo_nxt   = 1'b0;
          state_nxt     = RSP;
        end else if (tmo_cnt_q == TMO_W'(TMO_CYC - 1)) begin
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = '0;
          rsp_err_nxt   = 1'b0;
          rsp_tmo_nxt   = 1'b1;
          state_nxt     = RSP;
        end else begin
          tmo_cnt_nxt = tmo_cnt_q + TMO_W'(1);
        end
      end
      RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_nxt = 1'b0;
          rsp_rdata_nxt = '0;
          rsp_err_nxt   = 1'b0;
          rsp_tmo_nxt   = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      tmo_cnt_q   <= '0;
      sys_addr_o  <= '0;
      sys_wdata_o <= '0;
      sys_sel_o   <= '0;
      sys_wen_o   <= 1'b0;
      sys_ren_o   <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      rsp_tmo_o   <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      we_q        <= we_nxt;
      tmo_cnt_q   <= tmo_cnt_nxt;
      sys_addr_o  <= addr_nxt;
      sys_wdata_o <= wdata_nxt;
      sys_sel_o   <= sel_nxt;
      sys_wen_o   <= wen_nxt;
      sys_ren_o   <= ren_nxt;
      rsp_valid_o <= rsp_valid_nxt;
      rsp_rdata_o <= rsp_rdata_nxt;
      rsp_err_o   <= rsp_err_nxt;
      rsp_tmo_o   <= rsp_tmo_nxt;
    end
  end

endmodule

// File: tb/tb_red_pitaya_sys_initiator.sv
// Scoreboard bench for red_pitaya_sys_initiator with a scripted sys_* responder.
module tb_red_pitaya_sys_initiator;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 8;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] data;
    int          dly;
    logic        err;
    logic        noack;
    logic        early;
    logic        stale;
  } rcfg_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_tmo_o;
  logic [31:0] sys_addr_o;
  logic [31:0] sys_wdata_o;
  logic [3:0]  sys_sel_o;
  logic        sys_wen_o;
  logic        sys_ren_o;
  logic [31:0] sys_rdata_i;
  logic        sys_err_i;
  logic        sys_ack_i;
  logic        busy_o;

  int n_chk  = 0;
  int n_fail = 0;

  rcfg_t rq[$];
  rsp_t  sb[$];

  always #5 clk_i = ~clk_i;

  red_pitaya_sys_initiator #(
    .CMD_DEPTH (DEPTH),
    .TMO_CYC   (TMO)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_wdata_i (cmd_wdata_i),
    .cmd_sel_i   (cmd_sel_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .rsp_tmo_o   (rsp_tmo_o),
    .sys_addr_o  (sys_addr_o),
    .sys_wdata_o (sys_wdata_o),
    .sys_sel_o   (sys_sel_o),
    .sys_wen_o   (sys_wen_o),
    .sys_ren_o   (sys_ren_o),
    .sys_rdata_i (sys_rdata_i),
    .sys_err_i   (sys_err_i),
    .sys_ack_i   (sys_ack_i),
    .busy_o      (busy_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  function automatic rcfg_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] sel, input logic [31:0] data, input int dly,
                               input logic err, input logic noack, input logic early,
                               input logic stale);
    rcfg_t c;
    c.we = we; c.addr = addr; c.wdata = wdata; c.sel = sel; c.data = data;
    c.dly = dly; c.err = err; c.noack = noack; c.early = early; c.stale = stale;
    return c;
  endfunction

  function automatic rsp_t er(input logic [31:0] rdata, input logic err, input logic tmo);
    rsp_t r;
    r.rdata = rdata; r.err = err; r.tmo = tmo;
    return r;
  endfunction

  // Offer one command; expectations are queued once it is certain to be accepted
  task automatic push_cmd(input rcfg_t c, input logic has_rsp, input rsp_t e);
    int n = 0;
    cmd_valid_i = 1'b1;
    cmd_we_i    = c.we;
    cmd_addr_i  = c.addr;
    cmd_wdata_i = c.wdata;
    cmd_sel_i   = c.sel;
    while (!cmd_ready_o && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!cmd_ready_o) begin
      fail("push_timeout");
      cmd_valid_i = 1'b0;
      return;
    end
    rq.push_back(c);
    if (has_rsp) sb.push_back(e);
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || rq.size() != 0) && n < 300) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (n >= 300) fail("drain_timeout");
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  // Response monitor: compares on each accepted response
  always @(negedge clk_i) begin
    if (!rst_i && rsp_valid_o && rsp_ready_i) begin
      if (sb.size() == 0) begin
        fail("unexpected_rsp");
      end else begin
        rsp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata_o, e.rdata);
        chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
        chk("rsp_tmo", 32'(rsp_tmo_o), 32'(e.tmo));
      end
    end
  end

  // Scripted responder: one config per strobe, in command order
  initial begin
    rcfg_t r;
    sys_ack_i   = 1'b0;
    sys_err_i   = 1'b0;
    sys_rdata_i = '0;
    forever begin
      @(posedge clk_i); #1;
      if (!rst_i && (sys_wen_o || sys_ren_o)) begin
        if (rq.size() == 0) begin
          fail("unexpected_strobe");
        end else begin
          r = rq.pop_front();
          chk("strobe_kind", 32'({sys_wen_o, sys_ren_o}), 32'({r.we, ~r.we}));
          chk("strobe_addr", sys_addr_o, r.addr);
          chk("strobe_sel", 32'(sys_sel_o), 32'(r.sel));
          if (r.we) chk("strobe_wdata", sys_wdata_o, r.wdata);
          if (r.early) begin
            sys_ack_i   = 1'b1;
            sys_rdata_i = 32'hDEAD_BEEF;
          end
          @(posedge clk_i); #1;
          sys_ack_i   = 1'b0;
          sys_rdata_i = '0;
          chk("strobe_width", 32'({sys_wen_o, sys_ren_o}), 32'h0);
          if (r.noack) begin
            repeat (TMO - 1) begin @(posedge clk_i); #1; end
            chk("tmo_not_early", 32'(rsp_valid_o), 32'h0);
            chk("tmo_addr_held", sys_addr_o, r.addr);
            @(posedge clk_i); #1;
            chk("tmo_valid", 32'(rsp_valid_o), 32'h1);
            chk("tmo_flag", 32'(rsp_tmo_o), 32'h1);
          end else begin
            repeat (r.dly - 1) begin @(posedge clk_i); #1; end
            if (!r.stale) begin
              chk("wait_addr_held", sys_addr_o, r.addr);
              chk("wait_sel_held", 32'(sys_sel_o), 32'(r.sel));
            end
            sys_ack_i   = 1'b1;
            sys_err_i   = r.err;
            sys_rdata_i = r.data;
            @(posedge clk_i); #1;
            sys_ack_i   = 1'b0;
            sys_err_i   = 1'b0;
            sys_rdata_i = '0;
            if (!r.stale) chk("ack_to_valid", 32'(rsp_valid_o), 32'h1);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'b0;
    cmd_addr_i  = '0;
    cmd_wdata_i = '0;
    cmd_sel_i   = '0;
    rsp_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata_o, 32'h0);
    chk("rst_sys_addr", sys_addr_o, 32'h0);
    chk("rst_strobes", 32'({sys_wen_o, sys_ren_o}), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);

    // Single write, ack three cycles into WAIT
    push_cmd(mk(1'b1, 32'h14, 32'h0123, 4'hF, 32'hFFFF_FFFF, 3, 1'b0, 1'b0, 1'b0, 1'b0),
             1'b1, er(32'h0, 1'b0, 1'b0));
    wait_done();

    // Single read, ack in the first WAIT cycle
    push_cmd(mk(1'b0, 32'h10, 32'h0, 4'hF, 32'h0000_1FFF, 1, 1'b0, 1'b0, 1'b0, 1'b0),
             1'b1, er(32'h0000_1FFF, 1'b0, 1'b0));
    wait_done();

    // Five back-to-back commands with responses stalled: four buffered, one in flight
    rsp_ready_i = 1'b0;
    push_cmd(mk(1'b0, 32'h20, 32'h0, 4'hF, 32'h0000_0A01, 1, 1'b0, 1'b0, 1'b0, 1'b0),
             1'b1, er(32'h0000_0A01, 1'b0, 1'b0));
    push_cmd(mk(1'b1, 32'h24, 32'h5555, 4'h3, 32'h1111_1111, 2, 1'b0, 1'b0, 1'b0, 1'b0),
             1'b1, er(32'h0, 1'b0, 1'b0));
    push_cmd(mk(1'b0, 32'h28, 32'h0, 4'hC, 32'h0000_0C03, 1, 1'b0, 1'b0, 1'b0, 1'b0),
             1'b1, er(32'h0000_0C03, 1'b0, 1'b0));
    push_cmd(mk(1'b0, 32'h2C, 32'h0, 4'hF, 32'h1234_5678, 4, 1'b0, 1'b0, 1'b0, 1'b0),
             1'b1, er(32'h1234_5678, 1'b0, 1'b0));
    push_cmd(mk(1'b1, 32'h30, 32'hAAAA, 4'h1, 32'h2222_2222, 1, 1'b0, 1'b0, 1'b0, 1'b0),
             1'b1, er(32'h0, 1'b0, 1'b0));
    chk("full_cmd_ready", 32'(cmd_ready_o), 32'h0);
    chk("full_busy", 32'(busy_o), 32'h1);
    repeat (4) @(posedge clk_i);
    #1;
    chk("stalled_rsp_valid", 32'(rsp_valid_o), 32'h1);
    chk("stalled_rsp_rdata", rsp_rdata_o, 32'h0000_0A01);
    rsp_ready_i = 1'b1;
    wait_done();
    chk("drained_cmd_ready", 32'(cmd_ready_o), 32'h1);

    // Timeout, then a normal write proceeds
    push_cmd(mk(1'b0, 32'h40, 32'h0, 4'hF, 32'h0, 0, 1'b0, 1'b1, 1'b0, 1'b0),
             1'b1, er(32'h0, 1'b0, 1'b1));
    push_cmd(mk(1'b1, 32'h44, 32'h77, 4'hF, 32'h0, 1, 1'b0, 1'b0, 1'b0, 1'b0),
             1'b1, er(32'h0, 1'b0, 1'b0));
    wait_done();

    // ack+err together gives err; ack in the ISSUE cycle is ignored
    push_cmd(mk(1'b0, 32'h48, 32'h0, 4'hF, 32'hCAFE_0001, 2, 1'b1, 1'b0, 1'b0, 1'b0),
             1'b1, er(32'h0, 1'b1, 1'b0));
    push_cmd(mk(1'b0, 32'h4C, 32'h0, 4'hF, 32'h0000_3C3C, 2, 1'b0, 1'b0, 1'b1, 1'b0),
             1'b1, er(32'h0000_3C3C, 1'b0, 1'b0));
    wait_done();

    // Reset during WAIT, then a stale ack must not produce a response
    push_cmd(mk(1'b0, 32'h10, 32'h0, 4'hF, 32'h5A5A_5A5A, 3, 1'b0, 1'b0, 1'b0, 1'b1),
             1'b0, er(32'h0, 1'b0, 1'b0));
    n = 0;
    while (!sys_ren_o && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!sys_ren_o) fail("reset_test_no_strobe");
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    chk("post_rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    chk("post_rst_rsp_rdata", rsp_rdata_o, 32'h0);
    chk("post_rst_sys_addr", sys_addr_o, 32'h0);
    chk("post_rst_cmd_ready", 32'(cmd_ready_o), 32'h1);
    chk("post_rst_busy", 32'(busy_o), 32'h0);

    push_cmd(mk(1'b0, 32'h18, 32'h0, 4'h5, 32'h0000_0042, 1, 1'b0, 1'b0, 1'b0, 1'b0),
             1'b1, er(32'h0000_0042, 1'b0, 1'b0));
    wait_done();
    chk("final_busy", 32'(busy_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
